column_buffer_arbiter: RTL and testbench
========================================

Name: column_buffer_arbiter

Overview:
- Owns the single-port column RAM that holds two 320-entry column buffers (front/back) of {texture, distance}.
- Arbitrates that port between GPU column lookups (fixed priority) and CPU column writes.
- Schedules the front/back swap so it lands only in vertical blanking.
- Sits between the CPU memory-mapped write path, the column RAM and the GPU lookahead fetch logic.

Parameters:
- COLUMNS, 320, entries per buffer; valid indices 0..COLUMNS-1.
- INDEX_W, 9, column index width.
- DATA_W, 16, width of distance and of texture; RAM word is 2*DATA_W.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous, active-high reset.
- v_sync  in  1  VGA vertical sync, active low.
- gpu_rd_req  in  1  GPU lookup request, single-cycle pulse.
- gpu_rd_index  in  INDEX_W  column to read, sampled with gpu_rd_req.
- gpu_distance  out  DATA_W  registered read result.
- gpu_texture  out  DATA_W  registered read result.
- gpu_rd_valid  out  1  one-cycle pulse, result valid.
- cpu_wr_req  in  1  level request, held until ack.
- cpu_wr_index  in  INDEX_W  target column in back buffer.
- cpu_wr_data  in  2*DATA_W  {texture, distance}.
- cpu_wr_ack  out  1  one-cycle pulse, write consumed.
- cpu_wr_err  out  1  sticky flag, out-of-range write seen; cleared by clr.
- cpu_swap_req  in  1  pulse, request buffer swap.
- swap_pending  out  1  swap requested, not yet applied.
- swap_done  out  1  one-cycle pulse when front toggles.
- front_buffer  out  1  buffer the GPU reads.
- mem_addr  out  INDEX_W+1  {buffer, index}, registered.
- mem_we  out  1  registered write enable.
- mem_wdata  out  2*DATA_W  registered write data.
- mem_rdata  in  2*DATA_W  RAM read data, 1-cycle latency after mem_addr.
- clear_busy  out  1  see Optional Feature.

Behaviour:
- Reset (clr=1 at a clk edge):
  - state=IDLE, front_buffer=0, swap_pending=0, all pulses 0.
  - gpu_distance=0, gpu_texture=0, mem_we=0, mem_addr=0, cpu_wr_err=0.
  - An in-flight read or write is abandoned; no gpu_rd_valid or cpu_wr_ack is issued for it.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR.
- IDLE:
  - gpu_rd_req goes to RD_ADDR: mem_addr={front_buffer, gpu_rd_index}, mem_we=0.
  - Else cpu_wr_req goes to WR: mem_addr={~front_buffer, cpu_wr_index}, mem_we=1, mem_wdata=cpu_wr_data, cpu_wr_ack=1.
  - Both requests in the same cycle: GPU wins; CPU stays pending.
- RD_ADDR always goes to RD_DATA, the RAM latency cycle.
- RD_DATA:
  - Captures mem_rdata[DATA_W-1:0] into gpu_distance and the upper half into gpu_texture.
  - Pulses gpu_rd_valid, returns to IDLE.
  - GPU read latency is exactly 3 clk from gpu_rd_req to gpu_rd_valid.
- WR: mem_we=0 next cycle; returns to IDLE. A CPU request still high in the ack cycle is not re-granted until IDLE.
- gpu_rd_req arriving while not IDLE is a protocol violation; the GPU issues at most one per 4 clk. The block ignores it.
- Out-of-range indices (index >= COLUMNS):
  - GPU: reads return 0 with gpu_rd_valid still pulsed.
  - CPU: writes are acked but mem_we stays 0, and cpu_wr_err is set.
- Swap:
  - cpu_swap_req sets swap_pending; repeat requests while pending are merged.
  - A registered v_sync falling edge arms the swap. It applies on the first cycle with state=IDLE, v_sync=0, armed and pending.
  - On apply: front_buffer toggles, swap_pending=0, swap_done pulses.
  - If v_sync rises before the FSM reaches IDLE, the swap waits for the next frame.
  - At most one swap per v_sync low period.
  - swap_req coinciding with the falling edge counts for that frame.
  - CPU writes always target ~front_buffer as sampled at grant.

Optional Feature:
- Macro: COLUMN_BUFFER_CLEAR_EN.
- Defined:
  - After each swap, a clear sequencer writes 0 to new-back entries 0..COLUMNS-1, one per IDLE cycle not taken by GPU.
  - clear_busy=1 throughout; cpu_wr_ack is withheld while clear_busy.
  - A new swap is deferred until clear completes.
  - clr aborts the clear.
- Undefined: clear_busy tied 0; no automatic writes.

Decomposition:
- Package column_buffer_pkg: FSM state enum, COLUMNS, INDEX_W, DATA_W, and a function packing {buffer, index} into a RAM address.
- One sub-module: vsync_edge_detect (registered falling-edge pulse).

Test Plan:
- clr, then gpu_rd_req index 5 with RAM word 0x00AB_1234 at addr 5 -> gpu_rd_valid exactly 3 clk later; gpu_distance=0x1234, gpu_texture=0x00AB.
- gpu_rd_req and cpu_wr_req (index 7, 0xDEAD_BEEF) same cycle -> read served first; cpu_wr_ack on the write at addr {1,7}, 4 clk after request.
- cpu_wr_req index 320 -> ack pulse, mem_we stays 0, cpu_wr_err=1 until clr.
- cpu_swap_req with v_sync=1 -> swap_pending=1, front unchanged; v_sync falls while in RD_DATA -> swap_done one cycle after IDLE, front_buffer=1.
- Two cpu_swap_req in one frame -> single toggle; clr asserted mid-read -> no gpu_rd_valid, front_buffer=0, swap_pending=0.
- With COLUMN_BUFFER_CLEAR_EN, no GPU traffic, swap -> clear_busy high 320 clk; back entries read 0; pending CPU write acked only after clear.

Source files
------------

// File: rtl/column_buffer_pkg.sv
// column_buffer_pkg: shared constants, FSM state type and RAM address packing
// for the column buffer arbiter.
package column_buffer_pkg;

  localparam int unsigned COLUMNS = 320;
  localparam int unsigned INDEX_W = 9;
  localparam int unsigned DATA_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  // RAM word address: buffer select on top of the column index.
  function automatic logic [INDEX_W:0] mem_address(input logic buf_sel,
                                                   input logic [INDEX_W-1:0] index);
    return {buf_sel, index};
  endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// vsync_edge_detect: registered one-cycle pulse on a falling edge of v_sync.
module vsync_edge_detect (
  input  logic clk,
  input  logic clr,
  input  logic v_sync,
  output logic fall_pulse
);

  logic v_sync_q;

  // Delay v_sync one cycle and flag a high-to-low transition.
  always_ff @(posedge clk) begin
    if (clr) begin
      v_sync_q   <= 1'b1;
      fall_pulse <= 1'b0;
    end else begin
      v_sync_q   <= v_sync;
      fall_pulse <= v_sync_q & ~v_sync;
    end
  end

endmodule

// File: rtl/column_buffer_arbiter.sv
// column_buffer_arbiter: owns the single-port column RAM holding front/back
// column buffers, arbitrates GPU lookups (priority) against CPU writes and
// lands the front/back swap inside vertical blanking.
// Optional: `define COLUMN_BUFFER_CLEAR_EN to zero the new back buffer after
// every swap.
module column_buffer_arbiter
  import column_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  v_sync,
  input  logic                  gpu_rd_req,
  input  logic [INDEX_W-1:0]    gpu_rd_index,
  output logic [DATA_W-1:0]     gpu_distance,
  output logic [DATA_W-1:0]     gpu_texture,
  output logic                  gpu_rd_valid,
  input  logic                  cpu_wr_req,
  input  logic [INDEX_W-1:0]    cpu_wr_index,
  input  logic [2*DATA_W-1:0]   cpu_wr_data,
  output logic                  cpu_wr_ack,
  output logic                  cpu_wr_err,
  input  logic                  cpu_swap_req,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  front_buffer,
  output logic [INDEX_W:0]      mem_addr,
  output logic                  mem_we,
  output logic [2*DATA_W-1:0]   mem_wdata,
  input  logic [2*DATA_W-1:0]   mem_rdata,
  output logic                  clear_busy
);

  localparam logic [INDEX_W-1:0] LAST_COL = INDEX_W'(COLUMNS - 1);

  state_t              state, state_nxt;
  logic [INDEX_W:0]    addr_nxt;
  logic                we_nxt, ack_nxt, valid_nxt, err_nxt;
  logic [2*DATA_W-1:0] wdata_nxt;
  logic [DATA_W-1:0]   dist_nxt, tex_nxt;
  logic                rd_oob, rd_oob_nxt;
  logic                gpu_in_range, cpu_in_range;
  logic                v_fall, armed, swap_apply, cpu_hold;

  assign gpu_in_range = (gpu_rd_index <= LAST_COL);
  assign cpu_in_range = (cpu_wr_index <= LAST_COL);

  vsync_edge_detect u_vsync_edge (
    .clk        (clk),
    .clr        (clr),
    .v_sync     (v_sync),
    .fall_pulse (v_fall)
  );

  // The falling-edge pulse arms the swap directly so it can land in the same
  // cycle the edge is seen; the armed register carries it until v_sync rises.
  assign swap_apply = (state == IDLE) && !v_sync && (armed || v_fall) &&
                      swap_pending && !clear_busy;

`ifdef COLUMN_BUFFER_CLEAR_EN
  logic [INDEX_W-1:0] clear_idx;
  logic               clear_step;

  // A CPU grant in the swap cycle would race the clear, so hold it off too.
  assign cpu_hold = clear_busy || swap_apply;

  // Clear sequencer: walk the new back buffer once after each swap.
  always_ff @(posedge clk) begin
    if (clr) begin
      clear_busy <= 1'b0;
      clear_idx  <= '0;
    end else if (swap_apply) begin
      clear_busy <= 1'b1;
      clear_idx  <= '0;
    end else if (clear_step) begin
      if (clear_idx == LAST_COL) clear_busy <= 1'b0;
      clear_idx <= clear_idx + INDEX_W'(1);
    end
  end
`else
  assign cpu_hold   = 1'b0;
  assign clear_busy = 1'b0;
`endif

  // Next-state and registered-output decode for the RAM port FSM.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = mem_addr;
    we_nxt     = 1'b0;
    wdata_nxt  = mem_wdata;
    ack_nxt    = 1'b0;
    valid_nxt  = 1'b0;
    err_nxt    = cpu_wr_err;
    dist_nxt   = gpu_distance;
    tex_nxt    = gpu_texture;
    rd_oob_nxt = rd_oob;
`ifdef COLUMN_BUFFER_CLEAR_EN
    clear_step = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (gpu_rd_req) begin
          state_nxt  = RD_ADDR;
          addr_nxt   = mem_address(front_buffer, gpu_rd_index);
          rd_oob_nxt = !gpu_in_range;
        end else if (cpu_wr_req && !cpu_hold) begin
          state_nxt = WR;
          addr_nxt  = mem_address(~front_buffer, cpu_wr_index);
          we_nxt    = cpu_in_range;
          wdata_nxt = cpu_wr_data;
          ack_nxt   = 1'b1;
          if (!cpu_in_range) err_nxt = 1'b1;
        end
`ifdef COLUMN_BUFFER_CLEAR_EN
        else if (clear_busy) begin
          addr_nxt   = mem_address(~front_buffer, clear_idx);
          we_nxt     = 1'b1;
          wdata_nxt  = '0;
          clear_step = 1'b1;
        end
`endif
      end
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: begin
        state_nxt = IDLE;
        valid_nxt = 1'b1;
        if (rd_oob) begin
          dist_nxt = '0;
          tex_nxt  = '0;
        end else begin
          dist_nxt = mem_rdata[DATA_W-1:0];
          tex_nxt  = mem_rdata[2*DATA_W-1:DATA_W];
        end
      end
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and RAM-port / GPU / CPU result registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      cpu_wr_ack   <= 1'b0;
      cpu_wr_err   <= 1'b0;
      gpu_rd_valid <= 1'b0;
      gpu_distance <= '0;
      gpu_texture  <= '0;
      rd_oob       <= 1'b0;
    end else begin
      state        <= state_nxt;
      mem_addr     <= addr_nxt;
      mem_we       <= we_nxt;
      mem_wdata    <= wdata_nxt;
      cpu_wr_ack   <= ack_nxt;
      cpu_wr_err   <= err_nxt;
      gpu_rd_valid <= valid_nxt;
      gpu_distance <= dist_nxt;
      gpu_texture  <= tex_nxt;
      rd_oob       <= rd_oob_nxt;
    end
  end

  // Swap bookkeeping: request merge, per-frame arming, front toggle.
  always_ff @(posedge clk) begin
    if (clr) begin
      front_buffer <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      armed        <= 1'b0;
    end else begin
      swap_done <= swap_apply;
      if (swap_apply) begin
        front_buffer <= ~front_buffer;
        armed        <= 1'b0;
      end else if (v_sync) begin
        armed <= 1'b0;
      end else if (v_fall) begin
        armed <= 1'b1;
      end
      if (swap_apply)        swap_pending <= 1'b0;
      else if (cpu_swap_req) swap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_column_buffer_arbiter.sv
// tb_column_buffer_arbiter: directed bench for column_buffer_arbiter with a
// behavioural 1-cycle-latency RAM. The clear-sequencer section is built only
// with COLUMN_BUFFER_CLEAR_EN defined.
module tb_column_buffer_arbiter;
  import column_buffer_pkg::*;

  logic                clk = 1'b0;
  logic                clr, v_sync;
  logic                gpu_rd_req;
  logic [INDEX_W-1:0]  gpu_rd_index;
  logic [DATA_W-1:0]   gpu_distance, gpu_texture;
  logic                gpu_rd_valid;
  logic                cpu_wr_req;
  logic [INDEX_W-1:0]  cpu_wr_index;
  logic [31:0]         cpu_wr_data;
  logic                cpu_wr_ack, cpu_wr_err;
  logic                cpu_swap_req, swap_pending, swap_done, front_buffer;
  logic [INDEX_W:0]    mem_addr;
  logic                mem_we;
  logic [31:0]         mem_wdata, mem_rdata;
  logic                clear_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:1023];
  logic        bk_we;
  logic [9:0]  bk_addr;
  logic [31:0] bk_data;

  always #5 clk = ~clk;

  column_buffer_arbiter dut (
    .clk          (clk),
    .clr          (clr),
    .v_sync       (v_sync),
    .gpu_rd_req   (gpu_rd_req),
    .gpu_rd_index (gpu_rd_index),
    .gpu_distance (gpu_distance),
    .gpu_texture  (gpu_texture),
    .gpu_rd_valid (gpu_rd_valid),
    .cpu_wr_req   (cpu_wr_req),
    .cpu_wr_index (cpu_wr_index),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ack   (cpu_wr_ack),
    .cpu_wr_err   (cpu_wr_err),
    .cpu_swap_req (cpu_swap_req),
    .swap_pending (swap_pending),
    .swap_done    (swap_done),
    .front_buffer (front_buffer),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .clear_busy   (clear_busy)
  );

  // Column RAM model with a backdoor preload port.
  always @(posedge clk) begin
    if (mem_we)     ram[mem_addr] <= mem_wdata;
    else if (bk_we) ram[bk_addr]  <= bk_data;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    tick();
    bk_we = 1'b0;
  endtask

  task automatic gpu_read(input string tag, input logic [INDEX_W-1:0] idx, input logic [31:0] exp_word);
    gpu_rd_req = 1'b1; gpu_rd_index = idx;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n == 1) gpu_rd_req = 1'b0;
      check_eq({tag, "_valid"}, 32'(gpu_rd_valid), (n == 3) ? 32'd1 : 32'd0);
      if (n == 3) begin
        check_eq({tag, "_dist"}, 32'(gpu_distance), {16'h0, exp_word[15:0]});
        check_eq({tag, "_tex"},  32'(gpu_texture),  {16'h0, exp_word[31:16]});
      end
    end
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (clear_busy && n < 1000) begin
      tick();
      n++;
    end
    if (clear_busy) check_eq("clear_timeout", 32'(clear_busy), 32'd0);
  endtask

  initial begin
    clr = 1'b1; v_sync = 1'b1; gpu_rd_req = 1'b0; gpu_rd_index = '0;
    cpu_wr_req = 1'b0; cpu_wr_index = '0; cpu_wr_data = '0; cpu_swap_req = 1'b0;
    bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    tick(); tick();
    clr = 1'b0;

    // Reset state
    check_eq("rst_front",   32'(front_buffer), 32'd0);
    check_eq("rst_pending", 32'(swap_pending), 32'd0);
    check_eq("rst_addr",    32'(mem_addr),     32'd0);
    check_eq("rst_we",      32'(mem_we),       32'd0);
    check_eq("rst_dist",    32'(gpu_distance), 32'd0);
    check_eq("rst_tex",     32'(gpu_texture),  32'd0);
    check_eq("rst_err",     32'(cpu_wr_err),   32'd0);
    check_eq("rst_valid",   32'(gpu_rd_valid), 32'd0);
    check_eq("rst_ack",     32'(cpu_wr_ack),   32'd0);
    check_eq("rst_done",    32'(swap_done),    32'd0);
    check_eq("rst_busy",    32'(clear_busy),   32'd0);

    poke(10'd5,   32'h00AB_1234);
    poke(10'd319, 32'h5A5A_A5A5);
    poke(10'd400, 32'hFFFF_FFFF);

    // Basic read, last valid column, out-of-range column
    gpu_read("rd5",   9'd5,   32'h00AB_1234);
    gpu_read("rd319", 9'd319, 32'h5A5A_A5A5);
    gpu_read("rd400", 9'd400, 32'h0000_0000);

    // Simultaneous GPU read and CPU write: GPU first, ack 4 clk later
    gpu_rd_req = 1'b1; gpu_rd_index = 9'd5;
    cpu_wr_req = 1'b1; cpu_wr_index = 9'd7; cpu_wr_data = 32'hDEAD_BEEF;
    for (int n = 1; n <= 4; n++) begin
      tick();
      if (n == 1) gpu_rd_req = 1'b0;
      check_eq("arb_valid", 32'(gpu_rd_valid), (n == 3) ? 32'd1 : 32'd0);
      check_eq("arb_ack",   32'(cpu_wr_ack),   (n == 4) ? 32'd1 : 32'd0);
      if (n == 3) check_eq("arb_dist", 32'(gpu_distance), 32'h0000_1234);
    end
    check_eq("arb_addr",  32'(mem_addr), 32'h0000_0207);
    check_eq("arb_we",    32'(mem_we),   32'd1);
    check_eq("arb_wdata", mem_wdata,     32'hDEAD_BEEF);
    cpu_wr_req = 1'b0;
    tick();
    check_eq("arb_ack_pulse", 32'(cpu_wr_ack), 32'd0);
    check_eq("arb_we_drop",   32'(mem_we),     32'd0);
    check_eq("arb_ram",       ram[10'h207],    32'hDEAD_BEEF);

    // Out-of-range CPU write
    cpu_wr_req = 1'b1; cpu_wr_index = 9'd320; cpu_wr_data = 32'h1111_2222;
    tick();
    cpu_wr_req = 1'b0;
    check_eq("oob_ack", 32'(cpu_wr_ack), 32'd1);
    check_eq("oob_we",  32'(mem_we),     32'd0);
    check_eq("oob_err", 32'(cpu_wr_err), 32'd1);
    tick();
    check_eq("oob_ack_pulse", 32'(cpu_wr_ack), 32'd0);
    check_eq("oob_err_hold",  32'(cpu_wr_err), 32'd1);

    // Swap requested outside blanking, v_sync falls during RD_DATA
    cpu_swap_req = 1'b1;
    tick();
    cpu_swap_req = 1'b0;
    check_eq("sw_pending", 32'(swap_pending), 32'd1);
    check_eq("sw_front0",  32'(front_buffer), 32'd0);
    gpu_rd_req = 1'b1; gpu_rd_index = 9'd5;
    tick();
    gpu_rd_req = 1'b0;
    tick();
    v_sync = 1'b0;
    tick();
    check_eq("sw_rd_valid",  32'(gpu_rd_valid), 32'd1);
    check_eq("sw_done_early", 32'(swap_done),   32'd0);
    tick();
    check_eq("sw_done",       32'(swap_done),    32'd1);
    check_eq("sw_front1",     32'(front_buffer), 32'd1);
    check_eq("sw_pending_clr", 32'(swap_pending), 32'd0);
    tick();
    check_eq("sw_done_pulse", 32'(swap_done), 32'd0);
    wait_clear();
    v_sync = 1'b1;
    tick(); tick();

    // Two requests in one frame merge into a single toggle
    cpu_swap_req = 1'b1; tick(); cpu_swap_req = 1'b0; tick();
    cpu_swap_req = 1'b1; tick(); cpu_swap_req = 1'b0;
    v_sync = 1'b0;
    tick();
    check_eq("dbl_done_early", 32'(swap_done), 32'd0);
    tick();
    check_eq("dbl_done",  32'(swap_done),    32'd1);
    check_eq("dbl_front", 32'(front_buffer), 32'd0);
    tick();
    check_eq("dbl_pending", 32'(swap_pending), 32'd0);
    wait_clear();

    // Only one swap per v_sync low period
    cpu_swap_req = 1'b1; tick(); cpu_swap_req = 1'b0;
    check_eq("one_pending", 32'(swap_pending), 32'd1);
    tick(); tick(); tick();
    check_eq("one_front", 32'(front_buffer), 32'd0);
    check_eq("one_done",  32'(swap_done),    32'd0);
    v_sync = 1'b1; tick(); tick();
    v_sync = 1'b0; tick(); tick();
    check_eq("nxt_done",  32'(swap_done),    32'd1);
    check_eq("nxt_front", 32'(front_buffer), 32'd1);
    wait_clear();
    check_eq("err_sticky", 32'(cpu_wr_err), 32'd1);

    // clr in the middle of a read abandons it
    cpu_swap_req = 1'b1; tick(); cpu_swap_req = 1'b0;
    v_sync = 1'b1; tick();
    gpu_rd_req = 1'b1; gpu_rd_index = 9'd5;
    tick();
    gpu_rd_req = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_valid",   32'(gpu_rd_valid), 32'd0);
    check_eq("clr_front",   32'(front_buffer), 32'd0);
    check_eq("clr_pending", 32'(swap_pending), 32'd0);
    check_eq("clr_err",     32'(cpu_wr_err),   32'd0);
    check_eq("clr_dist",    32'(gpu_distance), 32'd0);
    tick();
    check_eq("clr_no_late_valid", 32'(gpu_rd_valid), 32'd0);

    // v_sync rising before the FSM is idle defers the swap a frame
    cpu_swap_req = 1'b1; tick(); cpu_swap_req = 1'b0;
    gpu_rd_req = 1'b1; gpu_rd_index = 9'd5;
    tick();
    gpu_rd_req = 1'b0;
    v_sync = 1'b0;
    tick();
    v_sync = 1'b1;
    tick(); tick(); tick();
    check_eq("late_front",   32'(front_buffer), 32'd0);
    check_eq("late_pending", 32'(swap_pending), 32'd1);
    v_sync = 1'b0; tick(); tick();
    check_eq("late_done",  32'(swap_done),    32'd1);
    check_eq("late_front1", 32'(front_buffer), 32'd1);
    wait_clear();
    v_sync = 1'b1; tick();

`ifdef COLUMN_BUFFER_CLEAR_EN
    // Clear sequencer: 320 busy cycles, CPU ack withheld, back buffer zeroed
    begin
      int  n;
      logic early_ack, got_ack;
      clr = 1'b1; tick(); clr = 1'b0;
      poke(10'd0,   32'h1234_5678);
      poke(10'd319, 32'h8765_4321);
      poke(10'd320, 32'h0BAD_F00D);
      poke(10'd3,   32'h7777_7777);
      cpu_swap_req = 1'b1; tick(); cpu_swap_req = 1'b0;
      v_sync = 1'b0; tick(); tick();
      check_eq("clr_en_front", 32'(front_buffer), 32'd1);
      check_eq("clr_en_busy",  32'(clear_busy),   32'd1);
      cpu_wr_req = 1'b1; cpu_wr_index = 9'd3; cpu_wr_data = 32'hCAFE_0001;
      n = 0; early_ack = 1'b0;
      while (clear_busy && n < 400) begin
        if (cpu_wr_ack) early_ack = 1'b1;
        tick();
        n++;
      end
      check_eq("clr_en_cycles",    32'(n),         32'd320);
      check_eq("clr_en_early_ack", 32'(early_ack), 32'd0);
      got_ack = 1'b0;
      for (int i = 0; i < 5 && !got_ack; i++) begin
        if (cpu_wr_ack) got_ack = 1'b1;
        else tick();
      end
      cpu_wr_req = 1'b0;
      check_eq("clr_en_ack", 32'(got_ack), 32'd1);
      tick(); tick();
      check_eq("clr_en_ram0",   ram[10'd0],   32'd0);
      check_eq("clr_en_ram319", ram[10'd319], 32'd0);
      check_eq("clr_en_ram320", ram[10'd320], 32'h0BAD_F00D);
      check_eq("clr_en_ram3",   ram[10'd3],   32'hCAFE_0001);
      v_sync = 1'b1; tick();
    end
`else
    check_eq("no_clear_busy", 32'(clear_busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
